// File: rtl/sensor_conditioner_if.sv
// Field-sensor bundle between the raw probe side and the conditioned outputs
// consumed by the irrigation controller.
interface sensor_conditioner_if;
  logic h_raw;
  logic m_raw;
  logic l_raw;
  logic us_raw;
  logic ua_raw;
  logic t_raw;
  logic fault_clr;
  logic h;
  logic m;
  logic l;
  logic us;
  logic ua;
  logic t;
  logic valid;
  logic sensor_fault;
  logic level_change;

  modport master (
    output h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw, fault_clr,
    input  h, m, l, us, ua, t, valid, sensor_fault, level_change
  );

  modport slave (
    input  h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw, fault_clr,
    output h, m, l, us, ua, t, valid, sensor_fault, level_change
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Synchronise, debounce and sanity-check the six irrigation field sensors.
// Optional macro SENSOR_FORCE_SAFE_EN: report an empty tank while sensor_fault is set.
module sensor_conditioner #(
  parameter int unsigned DEB_COUNT    = 16,
  parameter int unsigned FAULT_CYCLES = 32
) (
  input logic clk,
  input logic rst_n,
  sensor_conditioner_if.slave bus
);
  localparam int unsigned NumCh  = 6;
  localparam int unsigned DebW   = $clog2(DEB_COUNT + 1);
  localparam int unsigned StartW = $clog2(DEB_COUNT + 2);
  localparam int unsigned FaultW = $clog2(FAULT_CYCLES + 1);
  localparam logic [DebW-1:0]   DebLast   = DebW'(DEB_COUNT - 1);
  localparam logic [StartW-1:0] StartLast = StartW'(DEB_COUNT + 1);
  localparam logic [FaultW-1:0] FaultLast = FaultW'(FAULT_CYCLES - 1);
  localparam logic [FaultW-1:0] FaultMax  = FaultW'(FAULT_CYCLES);

  // Channel order: [5]=h [4]=m [3]=l [2]=us [1]=ua [0]=t
  logic [NumCh-1:0]  rawVec;
  logic [NumCh-1:0]  sync1;
  logic [NumCh-1:0]  sync2;
  logic [NumCh-1:0]  deb;
  logic [NumCh-1:0]  debNext;
  logic [DebW-1:0]   debCnt     [NumCh];
  logic [DebW-1:0]   debCntNext [NumCh];
  logic [StartW-1:0] startCnt;
  logic              valid;
  logic [FaultW-1:0] faultCnt;
  logic [FaultW-1:0] faultCntNext;
  logic              sensorFault;
  logic              sensorFaultNext;
  logic              illegal;
  logic              faultSet;
  logic [2:0]        levelQ;
  logic [2:0]        levelPrev;
  logic [2:0]        levelNext;
  logic              levelChange;

  assign rawVec = {bus.h_raw, bus.m_raw, bus.l_raw, bus.us_raw, bus.ua_raw, bus.t_raw};

  // Debounce: the counter only advances while the synced value disagrees.
  always_comb begin
    debNext = deb;
    for (int i = 0; i < NumCh; i++) begin
      debCntNext[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (debCnt[i] == DebLast) begin
          debNext[i] = sync2[i];
        end else begin
          debCntNext[i] = debCnt[i] + DebW'(1);
        end
      end
    end
  end

  // Fault tracking; a set on the same edge as fault_clr takes priority.
  always_comb begin
    illegal         = (deb[5] & ~deb[4]) | (deb[4] & ~deb[3]);
    faultSet        = illegal && (faultCnt == FaultLast);
    faultCntNext    = faultCnt;
    sensorFaultNext = sensorFault;
    if (!illegal) begin
      faultCntNext = '0;
    end else if (faultCnt != FaultMax) begin
      faultCntNext = faultCnt + FaultW'(1);
    end
    if (bus.fault_clr && !faultSet) begin
      faultCntNext = '0;
    end
    if (faultSet) begin
      sensorFaultNext = 1'b1;
    end else if (bus.fault_clr) begin
      sensorFaultNext = 1'b0;
    end
  end

  always_comb begin
    levelNext = debNext[5:3];
`ifdef SENSOR_FORCE_SAFE_EN
    if (sensorFault) begin
      levelNext = 3'b000;
    end
`else
    levelNext = debNext[5:3];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      deb         <= '0;
      for (int i = 0; i < NumCh; i++) begin
        debCnt[i] <= '0;
      end
      startCnt    <= '0;
      valid       <= 1'b0;
      faultCnt    <= '0;
      sensorFault <= 1'b0;
      levelQ      <= '0;
      levelPrev   <= '0;
      levelChange <= 1'b0;
    end else begin
      sync1       <= rawVec;
      sync2       <= sync1;
      deb         <= debNext;
      for (int i = 0; i < NumCh; i++) begin
        debCnt[i] <= debCntNext[i];
      end
      if (!valid) begin
        if (startCnt == StartLast) begin
          valid <= 1'b1;
        end else begin
          startCnt <= startCnt + StartW'(1);
        end
      end
      faultCnt    <= faultCntNext;
      sensorFault <= sensorFaultNext;
      levelQ      <= levelNext;
      levelPrev   <= levelQ;
      levelChange <= valid && (levelQ != levelPrev);
    end
  end

  assign bus.h            = levelQ[2];
  assign bus.m            = levelQ[1];
  assign bus.l            = levelQ[0];
  assign bus.us           = deb[2];
  assign bus.ua           = deb[1];
  assign bus.t            = deb[0];
  assign bus.valid        = valid;
  assign bus.sensor_fault = sensorFault;
  assign bus.level_change = levelChange;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with default DEB_COUNT=16, FAULT_CYCLES=32.
module tb_sensor_conditioner;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sensor_conditioner_if ifc ();

  sensor_conditioner dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

`ifdef SENSOR_FORCE_SAFE_EN
  localparam bit ForceSafe = 1'b1;
`else
  localparam bit ForceSafe = 1'b0;
`endif

  // Record: raw {h,m,l,us,ua,t}, fault_clr, edges to run, expected
  // {h,m,l,us,ua,t,valid,sensor_fault,level_change} after the last edge.
  typedef struct {
    logic [5:0] raw;
    logic       clr;
    int         edges;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setRaw(input logic [5:0] r);
    {ifc.h_raw, ifc.m_raw, ifc.l_raw, ifc.us_raw, ifc.ua_raw, ifc.t_raw} = r;
  endtask

  function automatic logic [8:0] outs();
    return {ifc.h, ifc.m, ifc.l, ifc.us, ifc.ua, ifc.t,
            ifc.valid, ifc.sensor_fault, ifc.level_change};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [5:0] r, input logic c, input int n,
                        input logic [8:0] expSafe, input logic [8:0] expPlain);
    vec_t v;
    v.raw   = r;
    v.clr   = c;
    v.edges = n;
    v.exp   = ForceSafe ? expSafe : expPlain;
    vecs.push_back(v);
  endtask

  initial begin
    int pulses;
    int usHigh;
    clk   = 1'b0;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ifc.fault_clr = 1'b0;
    setRaw(6'b000000);

    // Illegal h,l without m, then fault clear sequences, then legal recovery.
    addVec(6'b101000, 1'b0, 17, 9'b001_000_100, 9'b001_000_100);
    addVec(6'b101000, 1'b0,  1, 9'b101_000_100, 9'b101_000_100);
    addVec(6'b101000, 1'b0,  1, 9'b101_000_101, 9'b101_000_101);
    addVec(6'b101000, 1'b0, 30, 9'b101_000_100, 9'b101_000_100);
    addVec(6'b101000, 1'b0,  1, 9'b101_000_110, 9'b101_000_110);
    addVec(6'b101000, 1'b0,  1, 9'b000_000_110, 9'b101_000_110);
    addVec(6'b101000, 1'b0,  1, 9'b000_000_111, 9'b101_000_110);
    addVec(6'b101000, 1'b1,  1, 9'b000_000_100, 9'b101_000_100);
    addVec(6'b101000, 1'b0,  1, 9'b101_000_100, 9'b101_000_100);
    addVec(6'b101000, 1'b0,  1, 9'b101_000_101, 9'b101_000_100);
    addVec(6'b101000, 1'b0, 29, 9'b101_000_100, 9'b101_000_100);
    addVec(6'b101000, 1'b0,  1, 9'b101_000_110, 9'b101_000_110);
    addVec(6'b101000, 1'b1,  1, 9'b000_000_100, 9'b101_000_100);
    addVec(6'b101000, 1'b0, 30, 9'b101_000_100, 9'b101_000_100);
    addVec(6'b101000, 1'b0,  1, 9'b101_000_100, 9'b101_000_100);
    addVec(6'b101000, 1'b1,  1, 9'b101_000_110, 9'b101_000_110);
    addVec(6'b101000, 1'b0,  1, 9'b000_000_110, 9'b101_000_110);
    addVec(6'b101000, 1'b0,  1, 9'b000_000_111, 9'b101_000_110);
    addVec(6'b001000, 1'b0, 17, 9'b000_000_110, 9'b101_000_110);
    addVec(6'b001000, 1'b0,  1, 9'b000_000_110, 9'b001_000_110);
    addVec(6'b001000, 1'b1,  1, 9'b000_000_100, 9'b001_000_101);
    addVec(6'b001000, 1'b0,  1, 9'b001_000_100, 9'b001_000_100);
    addVec(6'b001000, 1'b0,  1, 9'b001_000_101, 9'b001_000_100);
    addVec(6'b001000, 1'b0, 40, 9'b001_000_100, 9'b001_000_100);
    // ua and t have no legality check and never raise level_change.
    addVec(6'b001011, 1'b0, 17, 9'b001_000_100, 9'b001_000_100);
    addVec(6'b001011, 1'b0,  1, 9'b001_011_100, 9'b001_011_100);
    addVec(6'b001011, 1'b0,  1, 9'b001_011_100, 9'b001_011_100);
    addVec(6'b001000, 1'b0, 18, 9'b001_000_100, 9'b001_000_100);

    // Reset and startup
    repeat (3) step();
    chk("reset_outs", 32'(outs()), 32'h0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (ifc.level_change) pulses++;
    end
    chk("startup_valid_e17", 32'(ifc.valid), 32'h0);
    step();
    if (ifc.level_change) pulses++;
    chk("startup_valid_e18", 32'(ifc.valid), 32'h1);
    chk("startup_outs_e18", 32'(outs()), 32'(9'b000_000_100));
    chk("startup_no_lc", 32'(pulses), 32'h0);

    // Single level step on l
    setRaw(6'b001000);
    repeat (17) step();
    chk("l_e17", 32'(ifc.l), 32'h0);
    step();
    chk("l_e18", 32'(ifc.l), 32'h1);
    chk("l_lc_e18", 32'(ifc.level_change), 32'h0);
    step();
    chk("l_lc_e19", 32'(ifc.level_change), 32'h1);
    step();
    chk("l_lc_e20", 32'(ifc.level_change), 32'h0);

    // Glitch of 15 cycles on us is filtered
    setRaw(6'b001100);
    repeat (15) step();
    setRaw(6'b001000);
    usHigh = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (ifc.us) usHigh++;
    end
    chk("us_glitch15", 32'(usHigh), 32'h0);

    // 16-cycle pulse on us passes with matching width
    setRaw(6'b001100);
    repeat (16) step();
    setRaw(6'b001000);
    chk("us_p16_e16", 32'(ifc.us), 32'h0);
    repeat (2) step();
    chk("us_p16_e18", 32'(ifc.us), 32'h1);
    step();
    chk("us_p16_no_lc", 32'(ifc.level_change), 32'h0);
    repeat (14) step();
    chk("us_p16_e33", 32'(ifc.us), 32'h1);
    step();
    chk("us_p16_e34", 32'(ifc.us), 32'h0);
    repeat (5) step();

    // Table-driven fault / clear / recovery sequence
    for (int i = 0; i < vecs.size(); i++) begin
      setRaw(vecs[i].raw);
      ifc.fault_clr = vecs[i].clr;
      repeat (vecs[i].edges) step();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    ifc.fault_clr = 1'b0;

    // Reset mid-debounce discards progress
    setRaw(6'b010000);
    repeat (10) step();
    chk("m_pre_reset", 32'(ifc.m), 32'h0);
    rst_n = 1'b0;
    step();
    chk("m_in_reset", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    repeat (17) step();
    chk("m_post_e17", 32'({ifc.m, ifc.valid}), 32'h0);
    step();
    chk("m_post_e18", 32'({ifc.m, ifc.valid}), 32'h3);
    step();
    chk("m_post_lc_e19", 32'(ifc.level_change), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Front-end stage feeding the irrigation controller's raw inputs: h, m, l (tank level), us, ua (soil humidity) and t (temperature).
- Synchronises and debounces the six field sensor lines.
- Checks tank-level consistency: h implies m, m implies l.
- Flags a sticky sensor fault and reports level-change events for display and alarm logic.

Parameters:
DEB_COUNT, 16, consecutive stable cycles required before a debounced output changes (legal range 1..255)
FAULT_CYCLES, 32, consecutive cycles an illegal level combination must persist before sensor_fault sets (legal range 1..1023)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
h_raw, m_raw, l_raw  input  1 each  raw tank level probes (high/mid/low), asynchronous to clk
us_raw, ua_raw, t_raw  input  1 each  raw soil-dry, soil-wet and temperature-high sensors, asynchronous
fault_clr  input  1  clears sticky sensor_fault
h, m, l  output  1 each  conditioned tank level
us, ua, t  output  1 each  conditioned humidity/temperature
valid  output  1  conditioned outputs settled since reset
sensor_fault  output  1  sticky level-inconsistency flag
level_change  output  1  one-cycle pulse when conditioned h, m or l changes

Behaviour:
- Reset: rst_n sampled low at a rising edge clears the following to 0:
  - all synchroniser flops, debounce counters, startup counter and fault counter;
  - h, m, l, us, ua, t, valid, sensor_fault, level_change.
- Reset mid-operation aborts any debounce in progress. No state survives.
- Synchroniser: two flops per raw input.
- Debounce, per channel:
  - Counter width is the minimum bits needed to hold DEB_COUNT.
  - When the synced value differs from the channel's debounced value, the counter increments.
  - When the counter reaches DEB_COUNT, the debounced value takes the synced value and the counter clears.
  - When the synced value equals the debounced value, the counter clears.
  - A raw step held stable therefore appears at the output on the (DEB_COUNT+2)th rising edge after the change.
  - Any glitch shorter than DEB_COUNT cycles is discarded. The counter never wraps.
- Startup: a counter runs from reset release. valid asserts on edge DEB_COUNT+2 and stays high until the next reset. Outputs are driven regardless of valid.
- Level legality: the combination is illegal when (hd & ~md) | (md & ~ld), where hd, md, ld are the debounced h, m, l values.
- Fault counter:
  - Increments each cycle the combination is illegal and clears when it is legal.
  - Saturates at FAULT_CYCLES.
  - When it reaches FAULT_CYCLES, sensor_fault sets on that edge.
- sensor_fault stays set until fault_clr is high at an edge.
  - Clearing also zeroes the fault counter.
  - If fault_clr and a set condition coincide on the same edge, set wins.
  - An illegal combination still present after a clear re-sets the fault after a further FAULT_CYCLES cycles.
- level_change: registered pulse, high for exactly one cycle after any change of the h/l/m output values. Suppressed while valid is 0.
  - Forced-safe transitions (see Optional Feature) count as changes.
- us, ua and t have no legality check. They are the debounced values directly.

Optional Feature:
Macro SENSOR_FORCE_SAFE_EN.
- Defined: while sensor_fault is 1, outputs h, m and l are forced to 0 (tank reported empty). This raises the alarm and inhibits irrigation downstream. On clear, the debounced values return on the next cycle.
- Undefined: h, m and l always carry the debounced values. sensor_fault is informational only.
- us, ua and t are unaffected in both builds.

Test Plan:
1. rst_n low 3 cycles, then high, all raw inputs 0 -> valid rises on edge 18; all outputs 0; level_change never pulses.
2. After valid, l_raw 0->1 held -> l rises on edge 18 after the change; level_change high for exactly 1 cycle, the cycle after l rises.
3. us_raw pulses high for 15 cycles, then 0 -> us stays 0. A 16-cycle pulse -> us goes 1 at edge 18, back to 0 at edge 34 after the rise.
4. h_raw=1, m_raw=0, l_raw=1 from cycle 0 after valid -> h=1 at edge 18; sensor_fault set at edge 50.
   - With SENSOR_FORCE_SAFE_EN: h=0, l=0 from edge 51 and level_change pulses.
   - Without the macro: h and l hold 1.
5. With sensor_fault=1 and the illegal state persisting, fault_clr for 1 cycle -> sensor_fault 0 for 32 cycles, then re-sets. Same test with fault_clr asserted on the exact set edge -> sensor_fault stays 1.
6. m_raw held 1 for 10 cycles, then rst_n low for 1 edge, then released with m_raw still 1 -> m=0 during reset and until valid; m rises on edge 18 after release.
